multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multicycle MIPS main control FSM.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the datapath mux selects and write strobes.
- Produces the 2-bit ALUOp consumed by the downstream ALU control decoder: 00 add, 01 subtract, 10 decode funct.
- Sits between the instruction register opcode field and the datapath.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (gated in datapath).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback data select: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register select: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- ALUOp_sig  out  2  to ALU control.
- PCSource  out  2  PC source select: 00=ALU, 01=ALUOut, 10=jump target.
- illegal_op  out  1  unsupported opcode seen in DECODE.
- instr_done  out  1  final cycle of an instruction.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State is a register; outputs are decoded combinationally from state (Moore). Exceptions: PCWrite/IRWrite in FETCH are ANDed with mem_ready. All strobes not listed for a state are 0; selects not listed are 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state: lw/sw/addi -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; other -> FETCH with illegal_op=1 this cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: lw -> MEMRD; sw -> MEMWR; addi -> ADDIWB.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB:
  - Outputs: MemtoReg=1, RegDst=0, RegWrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until mem_ready, then goes to FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Next state: FETCH.
- ADDIWB:
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCSource=10, PCWrite=1.
  - Next state: FETCH.
- instr_done and retired counter:
  - instr_done=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR when mem_ready=1.
  - retired increments on the clock edge where instr_done=1; wraps at 2^CNT_W-1 -> 0.
  - Illegal opcodes do not retire.
- Latency with mem_ready held high: lw 5 cycles, sw/R/addi 4, beq/j 3.
- Opcode is sampled in DECODE and MEMADR. The IR is stable after FETCH, so no internal opcode copy is kept.
- Reset (asynchronous):
  - state=FETCH, retired=0.
  - While reset=1, all strobes (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite) and illegal_op/instr_done are forced 0; selects take FETCH values.
  - Reset mid-instruction aborts it immediately with no retire.
  - First fetch begins on the first edge after deassertion.
- Unreachable state encodings: all outputs 0, next state FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - 4-bit state encoding (FETCH=0 .. JUMP=10);
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10).
- The ALU control decoder imports the same ALUOp constants.
- One sub-module: mc_output_decode, a purely combinational state-to-control-vector mapping. The top level holds the state register, next-state logic, mem_ready gating, reset forcing and the counter.

Test Plan:
- Reset release, mem_ready=1, opcode=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1, MemtoReg=1 in cycle 5; retired 0->1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1, IorD=1 held 4 cycles; instr_done only on the mem_ready cycle; total 7 cycles.
- R-type (000000) -> ALUOp_sig=10, ALUSrcB=00 in EXEC; RegDst=1, RegWrite=1 next cycle; beq (000100) -> ALUOp_sig=01, PCWriteCond=1, PCSource=01 in cycle 3.
- FETCH with mem_ready=0 for 2 cycles -> MemRead=1, IRWrite=PCWrite=0; both 1 on the mem_ready cycle only.
- opcode=111111 -> illegal_op=1 in DECODE; FETCH next cycle; retired unchanged.
- Reset asserted mid-MEMRD -> all strobes 0 asynchronously, retired=0, state FETCH; j executes after release in 3 cycles with PCSource=10.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// ALUOp codes and the packed control vector produced by the output decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIWB = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10
    } state_e;

    // Raw per-state controls before mem_ready gating and reset forcing.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output table: maps the current state to its raw control vector.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    // Every field defaults to 0; each state only sets what it drives.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = 2'b00;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_source  = 2'b10;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: state register, next-state logic,
// mem_ready gating, reset forcing of strobes and retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 (IR/PC load when mem_ready)
// DECODE | register read, branch target calc, dispatch on opcode
// MEMADR | effective address / addi sum
// MEMRD  | load data read, held until mem_ready
// MEMWB  | load data written to rt
// MEMWR  | store write, held until mem_ready (retires on ready)
// EXEC   | R-type ALU operation
// ALUWB  | R-type result written to rd
// ADDIWB | addi result written to rt
// BRANCH | beq compare, conditional PC load
// JUMP   | PC load from jump target
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp_sig,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl;
    logic             illegal_raw;
    logic             done_raw;
    logic             fetch_gate;

    mc_output_decode u_output_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Next-state selection; the IR holds the opcode stable after FETCH.
    always_comb begin
        state_d     = state_q;
        illegal_raw = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW, OP_ADDI: state_d = MEMADR;
                    OP_RTYPE:              state_d = EXEC;
                    OP_BEQ:                state_d = BRANCH;
                    OP_J:                  state_d = JUMP;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                case (opcode)
                    OP_LW:   state_d = MEMRD;
                    OP_SW:   state_d = MEMWR;
                    OP_ADDI: state_d = ADDIWB;
                    default: state_d = FETCH;
                endcase
            end
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // A store retires on the cycle memory accepts it; FETCH loads wait for ready.
    always_comb begin
        done_raw   = ctrl.instr_done | ((state_q == MEMWR) & mem_ready);
        fetch_gate = (state_q != FETCH) | mem_ready;
        retired_d  = done_raw ? retired_q + CNT_W'(1) : retired_q;
    end

    // State and counter registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are forced low while reset is high; selects already show FETCH.
    assign PCWrite     = ~reset & ctrl.pc_write & fetch_gate;
    assign IRWrite     = ~reset & ctrl.ir_write & fetch_gate;
    assign PCWriteCond = ~reset & ctrl.pc_write_cond;
    assign MemRead     = ~reset & ctrl.mem_read;
    assign MemWrite    = ~reset & ctrl.mem_write;
    assign RegWrite    = ~reset & ctrl.reg_write;
    assign illegal_op  = ~reset & illegal_raw;
    assign instr_done  = ~reset & done_raw;
    assign IorD        = ctrl.i_or_d;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp_sig   = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control: each instruction is expanded
// into its expected per-cycle trace of control rows and compared every cycle.
module tb_multicycle_main_control;

    localparam int CNT_W = 8;

    localparam int PH_RESET  = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_MEMADR = 3;
    localparam int PH_MEMRD  = 4;
    localparam int PH_MEMWB  = 5;
    localparam int PH_MEMWR  = 6;
    localparam int PH_EXEC   = 7;
    localparam int PH_ALUWB  = 8;
    localparam int PH_ADDIWB = 9;
    localparam int PH_BRANCH = 10;
    localparam int PH_JUMP   = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp_sig, PCSource;
    logic             illegal_op, instr_done;
    logic [CNT_W-1:0] retired;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp_sig   (ALUOp_sig),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Row layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // RegDst RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] illegal_op instr_done
    function automatic logic [17:0] exp_row(input int ph, input bit rdy, input bit ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, il, dn;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, il, dn} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (ph)
            PH_RESET:  asb = 2'b01;
            PH_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            PH_DECODE: begin asb = 2'b11; il = ill; end
            PH_MEMADR: begin asa = 1; asb = 2'b10; end
            PH_MEMRD:  begin mr = 1; iord = 1; end
            PH_MEMWB:  begin m2r = 1; rw = 1; dn = 1; end
            PH_MEMWR:  begin mw = 1; iord = 1; dn = rdy; end
            PH_EXEC:   begin asa = 1; aop = 2'b10; end
            PH_ALUWB:  begin rd = 1; rw = 1; dn = 1; end
            PH_ADDIWB: begin rw = 1; dn = 1; end
            PH_BRANCH: begin asa = 1; aop = 2'b01; pcs = 2'b01; pcwc = 1; dn = 1; end
            PH_JUMP:   begin pcs = 2'b10; pcw = 1; dn = 1; end
            default:   ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, il, dn};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [17:0] obs_row();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp_sig, PCSource, illegal_op, instr_done};
    endfunction

    // Called just after a falling edge. Builds the instruction's cycle trace,
    // drives it, and compares every cycle. abort_at stops after that row.
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait,
                             input int abort_at);
        int ph_q[$];
        bit rdy_q[$];
        bit ill;
        logic [17:0] exp;
        ill = !is_legal(op);
        repeat (fetch_wait) begin ph_q.push_back(PH_FETCH); rdy_q.push_back(1'b0); end
        ph_q.push_back(PH_FETCH);  rdy_q.push_back(1'b1);
        ph_q.push_back(PH_DECODE); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (!ill) begin
            case (op)
                6'b100011: begin
                    ph_q.push_back(PH_MEMADR); rdy_q.push_back(1'($urandom_range(0, 1)));
                    repeat (mem_wait) begin ph_q.push_back(PH_MEMRD); rdy_q.push_back(1'b0); end
                    ph_q.push_back(PH_MEMRD);  rdy_q.push_back(1'b1);
                    ph_q.push_back(PH_MEMWB);  rdy_q.push_back(1'($urandom_range(0, 1)));
                end
                6'b101011: begin
                    ph_q.push_back(PH_MEMADR); rdy_q.push_back(1'($urandom_range(0, 1)));
                    repeat (mem_wait) begin ph_q.push_back(PH_MEMWR); rdy_q.push_back(1'b0); end
                    ph_q.push_back(PH_MEMWR);  rdy_q.push_back(1'b1);
                end
                6'b001000: begin
                    ph_q.push_back(PH_MEMADR); rdy_q.push_back(1'($urandom_range(0, 1)));
                    ph_q.push_back(PH_ADDIWB); rdy_q.push_back(1'($urandom_range(0, 1)));
                end
                6'b000000: begin
                    ph_q.push_back(PH_EXEC);   rdy_q.push_back(1'($urandom_range(0, 1)));
                    ph_q.push_back(PH_ALUWB);  rdy_q.push_back(1'($urandom_range(0, 1)));
                end
                6'b000100: begin ph_q.push_back(PH_BRANCH); rdy_q.push_back(1'($urandom_range(0, 1))); end
                default:   begin ph_q.push_back(PH_JUMP);   rdy_q.push_back(1'($urandom_range(0, 1))); end
            endcase
        end
        opcode = op;
        for (int i = 0; i < ph_q.size(); i++) begin
            mem_ready = rdy_q[i];
            #1;
            exp = exp_row(ph_q[i], rdy_q[i], ill);
            check($sformatf("ctrl op=%b row%0d", op, i), 32'(obs_row()), 32'(exp));
            check("retired", 32'(retired), 32'(exp_retired));
            if (exp[0]) exp_retired = exp_retired + 1'b1;
            if (i == abort_at) return;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] op;
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        #3;
        check("reset ctrl", 32'(obs_row()), 32'(exp_row(PH_RESET, 1'b1, 1'b0)));
        check("reset retired", 32'(retired), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'b100011, 0, 0, -1);
        run_instr(6'b101011, 0, 3, -1);
        run_instr(6'b000000, 0, 0, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b001000, 2, 0, -1);
        run_instr(6'b111111, 0, 0, -1);

        run_instr(6'b100011, 0, 3, 4);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        exp_retired = '0;
        check("midreset ctrl", 32'(obs_row()), 32'(exp_row(PH_RESET, 1'b1, 1'b0)));
        check("midreset retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        check("held reset ctrl", 32'(obs_row()), 32'(exp_row(PH_RESET, 1'b1, 1'b0)));
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'b000010, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0,
                      $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
